shift_add_mult: RTL and testbench
=================================

# shift_add_mult

Sequential unsigned shift-and-add multiplier. Computes a 2·SIZE-bit product over SIZE cycles by reusing a single `adder_p` instance (SIZE bits, `cin` tied 0) once per cycle. The block accepts operands through a start/busy/done handshake. It sits directly downstream of the ripple-carry adder: it drives the adder's operands and registers `SUM`/`cout` into a partial-product register. It is the first multi-cycle arithmetic unit in the datapath.

## Interface
- `SIZE`, default 32: operand width; product width is 2·SIZE; must be ≥ 2.

- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only when not busy.
- `a`  input  SIZE  multiplicand, unsigned; captured on accepted start.
- `b`  input  SIZE  multiplier, unsigned; captured on accepted start.
- `busy`  output  1  high while a multiplication is in progress.
- `done`  output  1  one-cycle pulse when `product` becomes valid.
- `product`  output  2·SIZE  result, registered; held until next accepted start.

## Operation
- Internal registers:
  - `M[SIZE-1:0]`: latched multiplicand.
  - `P[2·SIZE-1:0]`: partial product; `P_hi = P[2·SIZE-1:SIZE]`, `P_lo = P[SIZE-1:0]`.
  - `cnt`: clog2(SIZE+1) bits.
  - FSM state.
- Adder hookup: `A = P_hi`; `B = P[0] ? M : 0`; `cin = 0`.
- FSM states IDLE, RUN, DONE:
  - IDLE: `busy = 0`, `done = 0`. If `start`: `M ← a`, `P ← {SIZE'b0, b}`, `cnt ← 0`, go to RUN.
  - RUN: `busy = 1`. Each cycle: `P ← {cout, SUM, P_lo[SIZE-1:1]}` (add-then-shift-right by 1), `cnt ← cnt + 1`. When `cnt == SIZE-1` on this edge, go to DONE.
  - DONE: `done = 1`, `busy = 0`, `product = P`. If `start` is high, accept exactly as in IDLE and go to RUN. Otherwise go to IDLE.
- `product` is driven from a register loaded with the final `P` on the RUN→DONE transition. It is not overwritten until the next RUN→DONE transition.
- `start` while in RUN is ignored; changes on `a`/`b` during RUN have no effect.
- Arithmetic: unsigned only. Carry-out of each add is kept as bit 2·SIZE-1 of the shifted value, so no overflow is possible; result equals `a*b` exactly.
- Reset: state IDLE; `busy = 0`, `done = 0`, `product = 0`; `M`, `P`, `cnt` cleared. Reset mid-RUN aborts the operation with no `done` pulse. `product` reads 0 afterwards.

## Timing
- Start accepted on rising edge k (state IDLE or DONE, `start = 1`).
- `busy` is high in cycles k+1 … k+SIZE (exactly SIZE cycles).
- `done` is high in cycle k+SIZE+1 only; `product` is valid from that cycle.
- Back-to-back: `start` held high in the DONE cycle gives the next `busy` at k+SIZE+2. Throughput is one result per SIZE+1 cycles.
- `busy` and `done` are never high in the same cycle.
- The critical path is one SIZE-bit ripple add plus a mux; no combinational path from inputs to outputs.

## Configuration
- `SHIFT_ADD_ZERO_SKIP_EN`:
  - Defined: on an accepted start with `a == 0` or `b == 0`, skip RUN and go directly to DONE. `done` is high in cycle k+1, `product = 0`, and `busy` never asserts.
  - Undefined: zero operands take the full SIZE-cycle path like any other (`done` at k+SIZE+1, `product = 0`).
  - All non-zero operand timing is identical in both builds.

## Test plan
- SIZE=32, `a = 32'd6`, `b = 32'd7`, single start pulse → `busy` 32 cycles, `done` pulse at k+33, `product = 64'd42`, held afterwards.
- SIZE=32, `a = b = 32'hFFFF_FFFF` → `product = 64'hFFFF_FFFE_0000_0001`; also check SIZE=8 with `a = b = 8'hFF` → `16'hFE01` at k+9.
- `start` held continuously; `a`/`b` change every cycle → each result matches the operands sampled at its accept edge. Consecutive `done` pulses are exactly SIZE+1 cycles apart.
- `start` pulsed mid-RUN with different operands → ignored; the original product is delivered on schedule.
- `rst` asserted at cycle k+10 of a 32-bit run → next edge: `busy = 0`, `done = 0`, `product = 0`, state IDLE. No `done` pulse follows; a new start afterwards yields a correct result.
- `a = 0`, `b = 32'd123`: with `SHIFT_ADD_ZERO_SKIP_EN` → `done` at k+1, `busy` never high, `product = 0`. Without the macro → `done` at k+33, `product = 0`.

Source files
------------

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier built around one ripple-carry adder_p.
// Optional build macro SHIFT_ADD_ZERO_SKIP_EN: zero operands bypass RUN and finish in one cycle.

module adder_p #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            cin,
  output logic [SIZE-1:0] SUM,
  output logic            cout
);

  logic [SIZE:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    assign SUM[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign cout = carry[SIZE];

endmodule

module shift_add_mult #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product,
  output logic [1:0]        dbg_state_o
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);

  // Handshake: start is sampled on a rising edge only while busy is low
  // (IDLE or DONE); busy marks the SIZE RUN cycles, done is a one-cycle
  // pulse during which product is valid, and the two never overlap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SIZE-1:0]     m_q, m_d;
  logic [2*SIZE-1:0]   p_q, p_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*SIZE-1:0]   product_q, product_d;

  logic [SIZE-1:0]     add_a;
  logic [SIZE-1:0]     add_b;
  logic [SIZE-1:0]     add_sum;
  logic                add_cout;
  logic [2*SIZE-1:0]   p_shift;

  assign add_a = p_q[2*SIZE-1:SIZE];
  assign add_b = p_q[0] ? m_q : '0;

  adder_p #(
    .SIZE (SIZE)
  ) u_adder (
    .A    (add_a),
    .B    (add_b),
    .cin  (1'b0),
    .SUM  (add_sum),
    .cout (add_cout)
  );

  // Carry-out becomes the new MSB, so the shifted value never overflows.
  assign p_shift = {add_cout, add_sum, p_q[SIZE-1:1]};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          m_d     = a;
          p_d     = {{SIZE{1'b0}}, b};
          cnt_d   = '0;
          state_d = RUN;
`ifdef SHIFT_ADD_ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) begin
            state_d   = DONE;
            product_d = '0;
          end
`endif
        end
      end
      RUN: begin
        p_d   = p_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          product_d = p_shift;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign product     = product_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult: 32-bit and 8-bit instances, directed vectors.
// Honours SHIFT_ADD_ZERO_SKIP_EN when predicting zero-operand latency.

module tb_shift_add_mult;

  localparam int S32 = 32;
  localparam int S8  = 8;

  logic              clk;
  logic              rst;
  logic              start32, start8;
  logic [S32-1:0]    a32, b32;
  logic [S8-1:0]     a8, b8;
  logic              busy32, done32, busy8, done8;
  logic [2*S32-1:0]  product32;
  logic [2*S8-1:0]   product8;
  logic [1:0]        st32, st8;

  int cyc;
  int n_cmp;
  int n_fail;

  logic [2*S32-1:0] exp_q[$];
  int               exp_t_q[$];
  int               exp_bl_q[$];
  logic [2*S8-1:0]  exp8_q[$];
  int               exp8_t_q[$];
  int               blen32, blen8;

  shift_add_mult #(.SIZE(S32)) dut (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .product(product32), .dbg_state_o(st32)
  );

  shift_add_mult #(.SIZE(S8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8), .dbg_state_o(st8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks: called at a negedge; the following posedge is the accept edge k
  task automatic go32(input logic [S32-1:0] a, input logic [S32-1:0] b,
                      input logic [2*S32-1:0] exp);
    int k;
    bit zs;
    zs = 1'b0;
`ifdef SHIFT_ADD_ZERO_SKIP_EN
    zs = (a == '0) || (b == '0);
`endif
    k = cyc + 1;
    a32 = a;
    b32 = b;
    start32 = 1'b1;
    exp_q.push_back(exp);
    exp_t_q.push_back(zs ? k : k + S32);
    exp_bl_q.push_back(zs ? 0 : S32);
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic go8(input logic [S8-1:0] a, input logic [S8-1:0] b,
                     input logic [2*S8-1:0] exp);
    int k;
    k = cyc + 1;
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    exp8_q.push_back(exp);
    exp8_t_q.push_back(k + S8);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst) begin
      blen32 = 0;
    end else begin
      if (busy32 && done32) chk("busy_done_overlap32", 64'd1, 64'd0);
      if (done32) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done32", 64'd1, 64'd0);
        end else begin
          chk("product32", product32, exp_q.pop_front());
          chk("done_cycle32", 64'(cyc), 64'(exp_t_q.pop_front()));
          chk("busy_len32", 64'(blen32), 64'(exp_bl_q.pop_front()));
        end
        blen32 = 0;
      end else if (busy32) begin
        blen32++;
      end else begin
        blen32 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      blen8 = 0;
    end else begin
      if (busy8 && done8) chk("busy_done_overlap8", 64'd1, 64'd0);
      if (done8) begin
        if (exp8_q.size() == 0) begin
          chk("unexpected_done8", 64'd1, 64'd0);
        end else begin
          chk("product8", 64'(product8), 64'(exp8_q.pop_front()));
          chk("done_cycle8", 64'(cyc), 64'(exp8_t_q.pop_front()));
          chk("busy_len8", 64'(blen8), 64'(S8));
        end
        blen8 = 0;
      end else if (busy8) begin
        blen8++;
      end else begin
        blen8 = 0;
      end
    end
  end

  initial begin
    logic [S32-1:0] ha, hb;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    start32 = 1'b0;
    start8 = 1'b0;
    a32 = '0;
    b32 = '0;
    a8 = '0;
    b8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_product32", product32, 64'd0);
    chk("rst_state32", 64'(st32), 64'd0);
    chk("rst_product8", 64'(product8), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic 6*7 plus hold check
    go32(32'd6, 32'd7, 64'd42);
    repeat (S32 + 4) @(negedge clk);
    chk("hold32", product32, 64'd42);
    chk("idle_after_done32", 64'(st32), 64'd0);

    // all-ones operands
    go32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    repeat (S32 + 3) @(negedge clk);

    // 8-bit instance
    go8(8'hFF, 8'hFF, 16'hFE01);
    repeat (S8 + 3) @(negedge clk);
    go8(8'd13, 8'd11, 16'd143);
    repeat (S8 + 3) @(negedge clk);
    chk("hold8", 64'(product8), 64'd143);

    // start during RUN is ignored
    go32(32'd1000, 32'd3000, 64'd3000000);
    repeat (5) @(negedge clk);
    a32 = 32'd5;
    b32 = 32'd9;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (S32 + 3) @(negedge clk);
    chk("hold_after_ignored32", product32, 64'd3000000);

    // start held high, operands changing every cycle
    start32 = 1'b1;
    for (int i = 0; i < 3 * (S32 + 1); i++) begin
      ha = 32'h1357_9BDF + 32'(i) * 32'h0101_0103;
      hb = 32'h8000_0001 ^ (32'(i) * 32'h0003_0005);
      a32 = ha;
      b32 = hb;
      if ((i % (S32 + 1)) == 0) begin
        exp_q.push_back(64'(ha) * 64'(hb));
        exp_t_q.push_back(cyc + 1 + S32);
        exp_bl_q.push_back(S32);
      end
      @(negedge clk);
    end
    start32 = 1'b0;
    repeat (4) @(negedge clk);

    // reset in the middle of a run
    a32 = 32'd77;
    b32 = 32'd88;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy32", 64'(busy32), 64'd0);
    chk("midrst_done32", 64'(done32), 64'd0);
    chk("midrst_product32", product32, 64'd0);
    chk("midrst_state32", 64'(st32), 64'd0);
    rst = 1'b0;
    repeat (S32 + 5) @(negedge clk);
    chk("post_rst_product32", product32, 64'd0);
    go32(32'd250, 32'd4, 64'd1000);
    repeat (S32 + 3) @(negedge clk);

    // zero operand
    go32(32'd0, 32'd123, 64'd0);
    repeat (S32 + 3) @(negedge clk);
    chk("zero_hold32", product32, 64'd0);

    chk("pending32", 64'(exp_q.size()), 64'd0);
    chk("pending8", 64'(exp8_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
